tx_frame_buffer: RTL and testbench

Store-and-forward frame buffer that sits directly upstream of `tx_control`. It accepts a byte stream with frame delimiters from the bridge receive path and writes bytes into a data FIFO. It publishes each complete, good frame to `tx_control` as a length-FIFO entry. Bytes of a frame are visible to the read side only after the whole frame is committed. Runt, oversized, errored and overflowing frames are discarded and rewound.

---
 rtl/tx_frame_buffer.sv | 201 ++++++++++++++++++++
 tb/tb_tx_frame_buffer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_frame_buffer.sv
// Store-and-forward transmit frame buffer: bytes land in a data FIFO and only become
// readable once the whole frame is good; bad frames are rewound and counted.
module tx_frame_buffer #(
   parameter int DATA_DEPTH = 2048,
   parameter int LEN_DEPTH  = 16,
   parameter int MIN_FRAME  = 60,
   parameter int MAX_FRAME  = 1518
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  rx_data,
   input  logic        rx_valid,
   input  logic        rx_last,
   input  logic        rx_error,
   output logic [7:0]  tx_data,
   input  logic        nextByte,
   output logic        empty_buff,
   output logic [15:0] frm_len,
   input  logic        nextLen,
   output logic        empty_len_buff,
   output logic        drop_pulse,
   output logic [15:0] drop_cnt
);

   localparam int AW = $clog2(DATA_DEPTH);
   localparam int LW = $clog2(LEN_DEPTH);
   localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0] DATA_FULL  = {1'b1, {AW{1'b0}}};
   localparam logic [LW:0] LPTR_ONE   = {{LW{1'b0}}, 1'b1};
   localparam logic [LW:0] LEN_FULL   = {1'b1, {LW{1'b0}}};
   localparam logic [15:0] MIN_L      = 16'(MIN_FRAME);
   localparam logic [15:0] MAX_L      = 16'(MAX_FRAME);

   typedef enum logic [1:0] {S_IDLE, S_RECV, S_DROP} state_t;

   logic [7:0]  data_mem [DATA_DEPTH];
   logic [15:0] len_mem  [LEN_DEPTH];

   state_t      state_q, state_d;
   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] commit_ptr_q, commit_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] frame_start_q, frame_start_d;
   logic [15:0] len_cnt_q, len_cnt_d;
   logic [LW:0] len_wr_q, len_wr_d;
   logic [LW:0] len_rd_q, len_rd_d;
   logic [15:0] frm_len_q, frm_len_d;
   logic [15:0] drop_cnt_q, drop_cnt_d;
   logic        drop_pulse_q;
   logic [7:0]  tx_data_q;

   logic [AW:0] data_used;
   logic [LW:0] len_count;
   logic        data_full, len_full, len_empty;
   logic        wr_en, len_push, drop;
   logic [15:0] final_len;
   logic        byte_pop, len_pop;

   assign data_used  = wr_ptr_q - rd_ptr_q;
   assign data_full  = (data_used == DATA_FULL);
   assign len_count  = len_wr_q - len_rd_q;
   assign len_full   = (len_count == LEN_FULL);
   assign len_empty  = (len_wr_q == len_rd_q);

   assign empty_buff     = (commit_ptr_q == rd_ptr_q);
   assign empty_len_buff = len_empty;
   assign tx_data        = tx_data_q;
   assign frm_len        = frm_len_q;
   assign drop_pulse     = drop_pulse_q;
   assign drop_cnt       = drop_cnt_q;

   assign byte_pop = nextByte && !empty_buff;
   assign len_pop  = nextLen && !len_empty;

   // Write-side FSM; a drop anywhere rewinds wr_ptr to the start of the frame.
   always_comb begin
      state_d       = state_q;
      wr_ptr_d      = wr_ptr_q;
      commit_ptr_d  = commit_ptr_q;
      frame_start_d = frame_start_q;
      len_cnt_d     = len_cnt_q;
      wr_en         = 1'b0;
      len_push      = 1'b0;
      drop          = 1'b0;
      final_len     = len_cnt_q + 16'd1;
      case (state_q)
         S_IDLE: begin
            if (rx_valid) begin
               frame_start_d = wr_ptr_q;
               final_len     = 16'd1;
               if (data_full || rx_error) begin
                  drop = 1'b1;
               end else begin
                  wr_en     = 1'b1;
                  wr_ptr_d  = wr_ptr_q + PTR_ONE;
                  len_cnt_d = 16'd1;
                  state_d   = S_RECV;
                  if (rx_last) begin
                     if (final_len >= MIN_L && !len_full) begin
                        len_push     = 1'b1;
                        commit_ptr_d = wr_ptr_q + PTR_ONE;
                        state_d      = S_IDLE;
                     end else begin
                        drop = 1'b1;
                     end
                  end
               end
            end
         end
         S_RECV: begin
            if (rx_valid) begin
               if (data_full || len_cnt_q == MAX_L || rx_error) begin
                  drop = 1'b1;
               end else begin
                  wr_en     = 1'b1;
                  wr_ptr_d  = wr_ptr_q + PTR_ONE;
                  len_cnt_d = final_len;
                  if (rx_last) begin
                     if (final_len >= MIN_L && !len_full) begin
                        len_push     = 1'b1;
                        commit_ptr_d = wr_ptr_q + PTR_ONE;
                        state_d      = S_IDLE;
                     end else begin
                        drop = 1'b1;
                     end
                  end
               end
            end
         end
         S_DROP: begin
            if (rx_valid && rx_last) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
      if (drop) begin
         wr_en     = 1'b0;
         len_push  = 1'b0;
         wr_ptr_d  = frame_start_d;
         len_cnt_d = 16'd0;
         state_d   = rx_last ? S_IDLE : S_DROP;
      end
   end

   always_comb begin
      rd_ptr_d   = byte_pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      len_rd_d   = len_pop ? len_rd_q + LPTR_ONE : len_rd_q;
      len_wr_d   = len_push ? len_wr_q + LPTR_ONE : len_wr_q;
      drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
      // The new head is the entry being pushed when the FIFO is empty after any pop.
      if (len_rd_d == len_wr_q) begin
         frm_len_d = len_push ? final_len : 16'd0;
      end else begin
         frm_len_d = len_mem[len_rd_d[LW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= S_IDLE;
         wr_ptr_q      <= '0;
         commit_ptr_q  <= '0;
         rd_ptr_q      <= '0;
         frame_start_q <= '0;
         len_cnt_q     <= '0;
         len_wr_q      <= '0;
         len_rd_q      <= '0;
         frm_len_q     <= '0;
         drop_cnt_q    <= '0;
         drop_pulse_q  <= 1'b0;
         tx_data_q     <= '0;
      end else begin
         state_q       <= state_d;
         wr_ptr_q      <= wr_ptr_d;
         commit_ptr_q  <= commit_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         frame_start_q <= frame_start_d;
         len_cnt_q     <= len_cnt_d;
         len_wr_q      <= len_wr_d;
         len_rd_q      <= len_rd_d;
         frm_len_q     <= frm_len_d;
         drop_cnt_q    <= drop_cnt_d;
         drop_pulse_q  <= drop;
         tx_data_q     <= data_mem[rd_ptr_q[AW-1:0]];
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) begin
         data_mem[wr_ptr_q[AW-1:0]] <= rx_data;
      end
   end

   always_ff @(posedge clk) begin
      if (len_push) begin
         len_mem[len_wr_q[LW-1:0]] <= final_len;
      end
   end

endmodule

// File: tb/tb_tx_frame_buffer.sv
// Scoreboard bench for tx_frame_buffer: stimulus queues expected bytes, lengths and
// drop counts; independent monitors pop and compare as the DUT presents them.
module tb_tx_frame_buffer;

   localparam int DD   = 128;
   localparam int LD   = 16;
   localparam int MINF = 60;
   localparam int MAXF = 100;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_last, rx_error;
   logic [7:0]  tx_data;
   logic        nextByte, nextLen;
   logic        empty_buff, empty_len_buff, drop_pulse;
   logic [15:0] frm_len, drop_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0]  exp_byte_q[$];
   logic [15:0] exp_len_q[$];
   logic [15:0] exp_drop_q[$];
   logic [15:0] exp_drop_cnt = 16'd0;
   bit          byte_rd_en = 1'b0;
   bit          len_rd_en  = 1'b0;

   tx_frame_buffer #(
      .DATA_DEPTH(DD), .LEN_DEPTH(LD), .MIN_FRAME(MINF), .MAX_FRAME(MAXF)
   ) dut (
      .clk(clk), .rst(rst),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_error(rx_error),
      .tx_data(tx_data), .nextByte(nextByte), .empty_buff(empty_buff),
      .frm_len(frm_len), .nextLen(nextLen), .empty_len_buff(empty_len_buff),
      .drop_pulse(drop_pulse), .drop_cnt(drop_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Byte monitor: tx_data is trusted only when the buffer was non-empty at the previous sample.
   initial begin
      bit prev_ne;
      prev_ne  = 1'b0;
      nextByte = 1'b0;
      forever begin
         @(negedge clk);
         if (byte_rd_en && !empty_buff && prev_ne) begin
            if (exp_byte_q.size() == 0) begin
               chk("unexpected_byte", 32'(tx_data), 32'hFFFF_FFFF);
            end else begin
               chk("tx_data", 32'(tx_data), 32'(exp_byte_q.pop_front()));
            end
            nextByte = 1'b1;
            @(negedge clk);
            nextByte = 1'b0;
         end
         prev_ne = !empty_buff;
      end
   end

   initial begin
      nextLen = 1'b0;
      forever begin
         @(negedge clk);
         if (len_rd_en && !empty_len_buff) begin
            if (exp_len_q.size() == 0) begin
               chk("unexpected_len", 32'(frm_len), 32'hFFFF_FFFF);
            end else begin
               chk("frm_len", 32'(frm_len), 32'(exp_len_q.pop_front()));
            end
            nextLen = 1'b1;
            @(negedge clk);
            nextLen = 1'b0;
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         if (drop_pulse === 1'b1) begin
            if (exp_drop_q.size() == 0) begin
               chk("unexpected_drop", 32'(drop_cnt), 32'hFFFF_FFFF);
            end else begin
               chk("drop_cnt_at_pulse", 32'(drop_cnt), 32'(exp_drop_q.pop_front()));
            end
         end
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic send_frame(input int len, input int base, input int err_at, input int gap,
                             input bit exp_commit, input bit exp_drop);
      if (exp_commit) begin
         for (int i = 0; i < len; i++) exp_byte_q.push_back(8'(base + i));
         exp_len_q.push_back(16'(len));
      end
      if (exp_drop) begin
         exp_drop_cnt = exp_drop_cnt + 16'd1;
         exp_drop_q.push_back(exp_drop_cnt);
      end
      for (int i = 0; i < len; i++) begin
         @(negedge clk);
         rx_valid = 1'b1;
         rx_data  = 8'(base + i);
         rx_last  = (i == len - 1);
         rx_error = (i + 1 == err_at);
         for (int g = 0; g < gap; g++) begin
            @(negedge clk);
            rx_valid = 1'b0;
            rx_last  = 1'b0;
            rx_error = 1'b0;
         end
      end
      @(negedge clk);
      rx_valid = 1'b0;
      rx_last  = 1'b0;
      rx_error = 1'b0;
   endtask

   task automatic wait_drain(input string name, input bit bytes_only);
      int c;
      c = 0;
      while ((exp_byte_q.size() != 0 ||
              (!bytes_only && (exp_len_q.size() != 0 || exp_drop_q.size() != 0))) && c < 5000) begin
         @(negedge clk);
         c++;
      end
      repeat (3) @(negedge clk);
      if (bytes_only) chk(name, 32'(exp_byte_q.size()), 32'd0);
      else chk(name, 32'(exp_byte_q.size() + exp_len_q.size() + exp_drop_q.size()), 32'd0);
   endtask

   initial begin
      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_last = 1'b0; rx_error = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset_tx_data", 32'(tx_data), 32'd0);
      chk("reset_frm_len", 32'(frm_len), 32'd0);
      chk("reset_empty_buff", 32'(empty_buff), 32'd1);
      chk("reset_empty_len", 32'(empty_len_buff), 32'd1);
      chk("reset_drop_pulse", 32'(drop_pulse), 32'd0);
      chk("reset_drop_cnt", 32'(drop_cnt), 32'd0);

      // Single 64-byte frame with readers parked to observe commit timing.
      for (int i = 0; i < 64; i++) exp_byte_q.push_back(8'(i));
      exp_len_q.push_back(16'd64);
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         if (i == 63) chk("precommit_empty_buff", 32'(empty_buff), 32'd1);
         rx_valid = 1'b1; rx_data = 8'(i); rx_last = (i == 63); rx_error = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b0; rx_last = 1'b0;
      chk("commit_empty_len", 32'(empty_len_buff), 32'd0);
      chk("commit_frm_len", 32'(frm_len), 32'd64);
      chk("commit_empty_buff", 32'(empty_buff), 32'd0);
      @(negedge clk);
      chk("first_tx_data", 32'(tx_data), 32'h00);
      byte_rd_en = 1'b1; len_rd_en = 1'b1;
      wait_drain("drain_single", 1'b0);
      chk("empty_after_read", 32'(empty_buff), 32'd1);

      // Runt then minimum-length frame.
      send_frame(59, 8'h40, 0, 0, 1'b0, 1'b1);
      chk("runt_empty_buff", 32'(empty_buff), 32'd1);
      send_frame(60, 8'h80, 0, 0, 1'b1, 1'b0);
      wait_drain("drain_runt", 1'b0);
      chk("drop_cnt_runt", 32'(drop_cnt), 32'd1);

      // Oversize, maximum-length, and errored frames.
      send_frame(110, 8'h10, 0, 0, 1'b0, 1'b1);
      send_frame(MAXF, 8'h20, 0, 0, 1'b1, 1'b0);
      wait_drain("drain_oversize", 1'b0);
      send_frame(64, 8'h30, 10, 0, 1'b0, 1'b1);
      send_frame(60, 8'h90, 0, 0, 1'b1, 1'b0);
      send_frame(60, 8'hA0, 60, 0, 1'b0, 1'b1);
      send_frame(60, 8'hB0, 1, 0, 1'b0, 1'b1);
      send_frame(61, 8'hC0, 0, 0, 1'b1, 1'b0);
      wait_drain("drain_error", 1'b0);

      // Overflow with committed data parked, then reads across the pointer wrap.
      byte_rd_en = 1'b0; len_rd_en = 1'b0;
      send_frame(100, 8'h05, 0, 0, 1'b1, 1'b0);
      send_frame(60, 8'h70, 0, 0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("overflow_drop_cnt", 32'(drop_cnt), 32'(exp_drop_cnt));
      byte_rd_en = 1'b1; len_rd_en = 1'b1;
      wait_drain("drain_overflow", 1'b0);
      send_frame(60, 8'hD0, 0, 0, 1'b1, 1'b0);
      send_frame(60, 8'hE0, 0, 0, 1'b1, 1'b0);
      wait_drain("drain_wrap", 1'b0);

      // Length FIFO fills while bytes keep draining.
      len_rd_en = 1'b0;
      for (int k = 0; k < LD; k++) begin
         send_frame(60, 16 * k, 0, 0, 1'b1, 1'b0);
         wait_drain("drain_bytes_lenfill", 1'b1);
      end
      chk("len_full_not_empty", 32'(empty_len_buff), 32'd0);
      send_frame(60, 8'h55, 0, 0, 1'b0, 1'b1);
      repeat (3) @(negedge clk);
      chk("len_full_drop_cnt", 32'(drop_cnt), 32'(exp_drop_cnt));
      len_rd_en = 1'b1;
      send_frame(60, 8'h66, 0, 0, 1'b1, 1'b0);
      wait_drain("drain_lenfull", 1'b0);

      // Back-to-back stream with concurrent pops.
      send_frame(60, 8'h01, 0, 1, 1'b1, 1'b0);
      send_frame(70, 8'h41, 0, 1, 1'b1, 1'b0);
      send_frame(80, 8'h81, 0, 1, 1'b1, 1'b0);
      send_frame(65, 8'hC1, 0, 1, 1'b1, 1'b0);
      send_frame(60, 8'h11, 0, 0, 1'b1, 1'b0);
      wait_drain("drain_stream", 1'b0);

      // Reset in the middle of a frame.
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         rx_valid = 1'b1; rx_data = 8'(8'hF0 + i); rx_last = 1'b0; rx_error = 1'b0;
      end
      @(negedge clk);
      rx_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      chk("midreset_tx_data", 32'(tx_data), 32'd0);
      chk("midreset_frm_len", 32'(frm_len), 32'd0);
      chk("midreset_empty_buff", 32'(empty_buff), 32'd1);
      chk("midreset_empty_len", 32'(empty_len_buff), 32'd1);
      chk("midreset_drop_pulse", 32'(drop_pulse), 32'd0);
      chk("midreset_drop_cnt", 32'(drop_cnt), 32'd0);
      rst = 1'b0;
      exp_drop_cnt = 16'd0;
      send_frame(60, 8'h23, 0, 0, 1'b1, 1'b0);
      send_frame(20, 8'h77, 0, 0, 1'b0, 1'b1);
      wait_drain("drain_after_reset", 1'b0);
      chk("final_drop_cnt", 32'(drop_cnt), 32'd1);
      chk("final_empty_buff", 32'(empty_buff), 32'd1);
      chk("final_empty_len", 32'(empty_len_buff), 32'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
